// File: rtl/alu_result_fifo.sv
// -----------------------------------------------------------------------------
// alu_result_fifo
//
// Downstream stage of the 8-bit add/sub/AND datapath. Each accepted result
// triple (sum/difference, bitwise AND, op select) is stored in a DEPTH-entry
// FIFO together with a zero flag computed at push time. The head entry is
// presented to the consumer from registered state only. A running accumulator
// sums every accepted arithmetic result for checksum/debug readback.
//
// Parameters
//   DATA_W : width of the arithmetic and AND results
//   DEPTH  : FIFO entries, power of two, >= 2
//   ACC_W  : accumulator width, >= DATA_W
//
// Ports
//   clk       : rising-edge clock
//   rst_n     : asynchronous active-low reset (clears state, storage, acc)
//   in_valid  : upstream result valid
//   in_ready  : FIFO can accept this cycle (registered-count decode)
//   in_sum    : add/sub result from the datapath
//   in_and    : bitwise AND result from the datapath
//   in_sub    : op select that produced in_sum (1 = subtract)
//   out_valid : head entry valid (registered-count decode)
//   out_ready : consumer accepts head
//   out_sum   : head entry sum/difference
//   out_and   : head entry AND result
//   out_sub   : head entry op select
//   out_zero  : head entry sum was all-zero
//   count     : current occupancy
//   acc_clr   : synchronous accumulator clear (clear-then-add on a push)
//   acc       : running accumulator
// -----------------------------------------------------------------------------
module alu_result_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int ACC_W  = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_W-1:0]          in_sum,
    input  logic [DATA_W-1:0]          in_and,
    input  logic                       in_sub,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_sum,
    output logic [DATA_W-1:0]          out_and,
    output logic                       out_sub,
    output logic                       out_zero,
    output logic [$clog2(DEPTH+1)-1:0] count,
    input  logic                       acc_clr,
    output logic [ACC_W-1:0]           acc
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = $clog2(DEPTH+1);
    // Entry layout, MSB first: {sub, zero, and, sum}
    localparam int ENTRY_W = 2 * DATA_W + 2;

    // -------------------------------------------------------------------------
    // Helpers
    // -------------------------------------------------------------------------
    function automatic logic is_zero(input logic [DATA_W-1:0] value);
        return (value == {DATA_W{1'b0}});
    endfunction

    function automatic logic [ENTRY_W-1:0] pack_entry(
        input logic              sub,
        input logic [DATA_W-1:0] and_val,
        input logic [DATA_W-1:0] sum_val
    );
        return {sub, is_zero(sum_val), and_val, sum_val};
    endfunction

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q,  count_d;
    logic [ACC_W-1:0]   acc_q,    acc_d;

    logic               in_ready_s;
    logic               out_valid_s;
    logic               push_s;
    logic               pop_s;
    logic [ENTRY_W-1:0] wr_entry_s;
    logic [ENTRY_W-1:0] head_s;
    logic [ACC_W-1:0]   acc_base_s;
    logic [ACC_W-1:0]   acc_add_s;

    // Handshake decode: both flags come from the registered count only, so a
    // full FIFO cannot take a push in the same cycle as a pop.
    always_comb begin
        in_ready_s  = (count_q < CNT_W'(DEPTH));
        out_valid_s = (count_q != {CNT_W{1'b0}});
        push_s      = in_valid & in_ready_s;
        pop_s       = out_valid_s & out_ready;
        wr_entry_s  = pack_entry(in_sub, in_and, in_sum);
    end

    // Pointer and occupancy next-state
    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;

        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // Pointers are exactly log2(DEPTH) bits and wrap on overflow.
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
    end

    // Accumulator next-state: clear first, then add the pushed sum. The sum is
    // zero-extended regardless of in_sub; the datapath already wrapped it.
    always_comb begin
        acc_base_s = {ACC_W{1'b0}};
        acc_add_s  = {ACC_W{1'b0}};

        if (acc_clr) begin
            acc_base_s = {ACC_W{1'b0}};
        end else begin
            acc_base_s = acc_q;
        end

        if (push_s) begin
            acc_add_s = ACC_W'(in_sum);
        end else begin
            acc_add_s = {ACC_W{1'b0}};
        end

        acc_d = acc_base_s + acc_add_s;
    end

    // Control registers: pointers, occupancy, accumulator
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
            acc_q    <= {ACC_W{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            acc_q    <= acc_d;
        end
    end

    // Entry storage; cleared on reset so an empty FIFO shows zeros at the head.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {ENTRY_W{1'b0}};
            end
        end else begin
            if (push_s) begin
                mem_q[wr_ptr_q] <= wr_entry_s;
            end
        end
    end

    // Head read: storage at the registered read pointer, no path from in_*.
    always_comb begin
        head_s = mem_q[rd_ptr_q];
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_s;
    assign out_sum   = head_s[DATA_W-1:0];
    assign out_and   = head_s[2*DATA_W-1:DATA_W];
    assign out_zero  = head_s[2*DATA_W];
    assign out_sub   = head_s[2*DATA_W+1];
    assign count     = count_q;
    assign acc       = acc_q;

endmodule

// File: tb/tb_alu_result_fifo.sv
module tb_alu_result_fifo;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;
    localparam int ACC_W  = 16;
    localparam int CNT_W  = $clog2(DEPTH+1);

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_sum;
    logic [DATA_W-1:0] in_and;
    logic              in_sub;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_sum;
    logic [DATA_W-1:0] out_and;
    logic              out_sub;
    logic              out_zero;
    logic [CNT_W-1:0]  count;
    logic              acc_clr;
    logic [ACC_W-1:0]  acc;

    typedef struct packed {
        logic              sub;
        logic              zero;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] s;
    } ent_t;

    ent_t             sb_q[$];
    logic [ACC_W-1:0] m_acc;
    int               n_cmp = 0;
    int               n_err = 0;

    alu_result_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ACC_W(ACC_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_sum(in_sum), .in_and(in_and), .in_sub(in_sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_and(out_and), .out_sub(out_sub), .out_zero(out_zero),
        .count(count), .acc_clr(acc_clr), .acc(acc)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [7:0] s, input logic [7:0] a,
                         input logic sub, input logic ordy, input logic clr);
        in_valid  = v;
        in_sum    = s;
        in_and    = a;
        in_sub    = sub;
        out_ready = ordy;
        acc_clr   = clr;
    endtask

    // One clock: compare DUT against the scoreboard, update the model, advance.
    task automatic cycle();
        logic push;
        logic pop;
        ent_t e;
        check_val("in_ready",  in_ready,  (sb_q.size() < DEPTH));
        check_val("out_valid", out_valid, (sb_q.size() != 0));
        check_val("count",     count,     sb_q.size());
        check_val("acc",       acc,       m_acc);
        if (sb_q.size() != 0) begin
            check_val("head_sum",  out_sum,  sb_q[0].s);
            check_val("head_and",  out_and,  sb_q[0].a);
            check_val("head_sub",  out_sub,  sb_q[0].sub);
            check_val("head_zero", out_zero, sb_q[0].zero);
        end
        push = in_valid && (sb_q.size() < DEPTH);
        pop  = out_ready && (sb_q.size() != 0);
        if (pop) begin
            e = sb_q.pop_front();
        end
        if (push) begin
            e.sub  = in_sub;
            e.zero = (in_sum == 8'h00);
            e.a    = in_and;
            e.s    = in_sum;
            sb_q.push_back(e);
        end
        m_acc = (acc_clr ? 16'h0000 : m_acc) + (push ? {8'h00, in_sum} : 16'h0000);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        m_acc = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset release
        check_val("rst_out_valid", out_valid, 1'b0);
        check_val("rst_in_ready",  in_ready,  1'b1);
        check_val("rst_count",     count,     0);
        check_val("rst_acc",       acc,       16'h0000);
        check_val("rst_out_sum",   out_sum,   8'h00);
        check_val("rst_out_and",   out_and,   8'h00);
        check_val("rst_out_zero",  out_zero,  1'b0);
        check_val("rst_out_sub",   out_sub,   1'b0);

        // Single transfer
        drive(1'b1, 8'h2A, 8'h0F, 1'b0, 1'b0, 1'b0);
        cycle();
        drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        check_val("single_valid", out_valid, 1'b1);
        check_val("single_sum",   out_sum,   8'h2A);
        check_val("single_and",   out_and,   8'h0F);
        check_val("single_zero",  out_zero,  1'b0);
        check_val("single_count", count,     1);
        check_val("single_acc",   acc,       16'h002A);
        drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
        cycle();
        check_val("single_pop_count", count,     0);
        check_val("single_pop_valid", out_valid, 1'b0);

        // Fill and backpressure
        drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
        cycle();
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 8'(i), 8'(8'hF0 | i), 1'b0, 1'b0, 1'b0);
            cycle();
        end
        check_val("full_count", count,    4);
        check_val("full_ready", in_ready, 1'b0);
        drive(1'b1, 8'h05, 8'hF5, 1'b0, 1'b0, 1'b0);
        cycle();
        check_val("full_reject_count", count, 4);
        check_val("full_acc",          acc,   16'h000A);
        drive(1'b1, 8'h05, 8'hF5, 1'b0, 1'b1, 1'b0);
        cycle();
        check_val("after_pop_ready", in_ready, 1'b1);
        check_val("after_pop_count", count,    3);
        drive(1'b1, 8'h05, 8'hF5, 1'b0, 1'b0, 1'b0);
        cycle();
        check_val("refill_count", count, 4);
        drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
        for (int i = 2; i <= 5; i++) begin
            check_val("drain_order", out_sum, i);
            cycle();
        end

        // Simultaneous push/pop at count 2
        drive(1'b1, 8'h11, 8'h01, 1'b0, 1'b0, 1'b0);
        cycle();
        drive(1'b1, 8'h22, 8'h02, 1'b1, 1'b0, 1'b0);
        cycle();
        drive(1'b1, 8'h33, 8'h03, 1'b0, 1'b1, 1'b0);
        cycle();
        check_val("pushpop_count", count,   2);
        check_val("pushpop_head",  out_sum, 8'h22);
        drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
        cycle();
        cycle();
        // Empty with push and out_ready both high
        drive(1'b1, 8'h44, 8'h04, 1'b0, 1'b1, 1'b0);
        cycle();
        check_val("empty_pushpop_count", count, 1);
        drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
        cycle();

        // Zero flag and sub
        drive(1'b1, 8'h00, 8'hAA, 1'b1, 1'b0, 1'b0);
        cycle();
        drive(1'b1, 8'hFF, 8'h55, 1'b0, 1'b0, 1'b0);
        cycle();
        check_val("zero_flag", out_zero, 1'b1);
        check_val("sub_flag",  out_sub,  1'b1);
        drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
        cycle();
        check_val("nonzero_flag", out_zero, 1'b0);
        cycle();

        // Accumulator wrap over 300 pushes of 0xFF
        drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1);
        cycle();
        drive(1'b1, 8'hFF, 8'h0F, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 300; i++) begin
            cycle();
        end
        drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
        cycle();
        check_val("acc_wrap", acc, 16'h2AD4);
        drive(1'b1, 8'h10, 8'h00, 1'b0, 1'b1, 1'b1);
        cycle();
        check_val("acc_clr_push", acc, 16'h0010);
        drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1);
        cycle();
        check_val("acc_clr_only", acc, 16'h0000);

        // Async reset mid-stream
        drive(1'b1, 8'h21, 8'h00, 1'b0, 1'b0, 1'b0);
        cycle();
        drive(1'b1, 8'h32, 8'h00, 1'b0, 1'b0, 1'b0);
        cycle();
        drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        cycle();
        #2;
        rst_n = 1'b0;
        #1;
        check_val("async_count", count,     0);
        check_val("async_acc",   acc,       16'h0000);
        check_val("async_valid", out_valid, 1'b0);
        check_val("async_ready", in_ready,  1'b1);
        check_val("async_sum",   out_sum,   8'h00);
        sb_q.delete();
        m_acc = 16'h0000;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(1'b1, 8'h7E, 8'h3C, 1'b0, 1'b0, 1'b0);
        cycle();
        drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
        cycle();
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
